// File: rtl/multiplier_iter_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package multiplier_iter_pkg;

    localparam int XLEN         = 64;
    localparam int ACC_W        = 132;
    localparam int BOOTH_DIGITS = 34;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOOP  = 2'd1,
        FINAL = 2'd2
    } state_e;

    // Radix-4 Booth digit: magnitude is one-hot in {one, two} (or zero), sign in neg.
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Recode the multiplier bit triplet {b[2i+1], b[2i], b[2i-1]}.
    // The 3'b111 triplet (value -0) is encoded as plain zero so that it
    // contributes no complement and no +1 injection.
    function automatic booth_digit_t booth_encode(input logic [2:0] bits);
        booth_digit_t d;
        d.one = bits[1] ^ bits[0];
        d.two = (bits[2] & ~bits[1] & ~bits[0]) | (~bits[2] & bits[1] & bits[0]);
        d.neg = bits[2] & ~(bits[1] & bits[0]);
        return d;
    endfunction

endpackage

// File: rtl/adder_lookahead.sv
// Carry-lookahead adder built from 4-bit lookahead groups; group carries ripple
// between groups. W must be a multiple of 4.
module adder_lookahead #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Per-group lookahead equations, evaluated group by group.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < W / 4; i++) begin
            c[4*i+1] = g[4*i] | (p[4*i] & c[4*i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & c[4*i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
            c[4*i+4] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                     | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i])
                     | ((&p[4*i+3 -: 4]) & c[4*i]);
        end
    end

    assign sum  = p ^ c[W-1:0];
    assign cout = c[W];

endmodule

// File: rtl/booth_cell.sv
// One radix-4 Booth digit: select 0/+-A/+-2A from the already-shifted
// multiplicand and fold it into the carry-save accumulator.
module booth_cell
    import multiplier_iter_pkg::*;
(
    input  logic [2:0]       bits,
    input  logic [ACC_W-1:0] a_shift,
    input  logic [ACC_W-1:0] sum_in,
    input  logic [ACC_W-1:0] carry_in,
    output logic [ACC_W-1:0] sum_out,
    output logic [ACC_W-1:0] carry_out
);

    booth_digit_t digit;
    logic [ACC_W-1:0] mag;
    logic [ACC_W-1:0] pp;

    assign digit = booth_encode(bits);

    // Partial product selection. a_shift already carries the 2i weighting, so
    // its low 2i bits are zero and the one's complement fills them with ones.
    // Adding the +1 at bit 0 therefore ripples through those ones and lands at
    // bit 2i, exactly as a +1 injected at bit 2i would.
    always_comb begin
        mag = '0;
        if (digit.one) begin
            mag = a_shift;
        end else if (digit.two) begin
            mag = {a_shift[ACC_W-2:0], 1'b0};
        end
        pp = digit.neg ? ~mag : mag;
    end

    csa #(.W(ACC_W)) u_csa (
        .x  (sum_in),
        .y  (carry_in),
        .z  (pp),
        .ci (digit.neg),
        .s  (sum_out),
        .c  (carry_out)
    );

endmodule

// File: rtl/csa.sv
// 3:2 carry-save adder. The carry output is already weighted (shifted left by
// one) and its free LSB slot is filled from ci, which lets the caller inject a
// +1 without a fourth operand.
module csa #(
    parameter int W = 132
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    logic [W-2:0] maj;

    assign s   = x ^ y ^ z;
    assign maj = (x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]);
    assign c   = {maj, ci};

endmodule

// File: rtl/multiplier_iter.sv
// Iterative radix-4 Booth multiplier: 64x64 -> 128, CELL_NUM digits per cycle,
// carry-save accumulation, one carry-propagate add in the FINAL state.
module multiplier_iter
    import multiplier_iter_pkg::*;
#(
    parameter int CELL_NUM = 2  // legal values: 1, 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sign_a,
    input  logic            sign_b,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    input  logic            enable,
    output logic            busy,
    output logic            res_ready,
    output logic [XLEN-1:0] product_lo,
    output logic [XLEN-1:0] product_hi
);

    localparam int SHIFT = 2 * CELL_NUM;
    localparam int B_W   = XLEN + 4;   // 3 sign-extension bits + B + appended 0

    state_e           state_q, state_d;
    logic [ACC_W-1:0] a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] carry_q, carry_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  hi_q, hi_d;

    logic [ACC_W-1:0] loop_sum;
    logic [ACC_W-1:0] loop_carry;
    logic [XLEN-1:0]  cpa_lo;
    logic [XLEN-1:0]  cpa_hi;
    logic             cpa_mid_carry;
    logic             cpa_cout_unused;

    // Chain of Booth cells; cell gi handles digit (cnt + gi), so it sees A
    // shifted two further places and the next multiplier triplet.
    for (genvar gi = 0; gi < CELL_NUM; gi++) begin : g_cell
        logic [ACC_W-1:0] a_cell;
        logic [ACC_W-1:0] sum_in;
        logic [ACC_W-1:0] carry_in;
        logic [ACC_W-1:0] sum_out;
        logic [ACC_W-1:0] carry_out;

        assign a_cell = a_q << (2 * gi);

        if (gi == 0) begin : g_first
            assign sum_in   = sum_q;
            assign carry_in = carry_q;
        end else begin : g_next
            assign sum_in   = g_cell[gi-1].sum_out;
            assign carry_in = g_cell[gi-1].carry_out;
        end

        booth_cell u_cell (
            .bits      (b_q[2*gi+2 -: 3]),
            .a_shift   (a_cell),
            .sum_in    (sum_in),
            .carry_in  (carry_in),
            .sum_out   (sum_out),
            .carry_out (carry_out)
        );
    end

    assign loop_sum   = g_cell[CELL_NUM-1].sum_out;
    assign loop_carry = g_cell[CELL_NUM-1].carry_out;

    // Final resolve: two 64-bit lookahead adders chained on the carry; bits
    // above 127 of the accumulator do not affect the product.
    adder_lookahead #(.W(XLEN)) u_cpa_lo (
        .a    (sum_q[XLEN-1:0]),
        .b    (carry_q[XLEN-1:0]),
        .cin  (1'b0),
        .sum  (cpa_lo),
        .cout (cpa_mid_carry)
    );

    adder_lookahead #(.W(XLEN)) u_cpa_hi (
        .a    (sum_q[2*XLEN-1:XLEN]),
        .b    (carry_q[2*XLEN-1:XLEN]),
        .cin  (cpa_mid_carry),
        .sum  (cpa_hi),
        .cout (cpa_cout_unused)
    );

    // Next-state and datapath update for IDLE -> LOOP -> FINAL.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        lo_d    = lo_q;
        hi_d    = hi_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    a_d     = {{(ACC_W-XLEN){sign_a & multiplicand[XLEN-1]}}, multiplicand};
                    b_d     = {{3{sign_b & multiplier[XLEN-1]}}, multiplier, 1'b0};
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = LOOP;
                end
            end
            LOOP: begin
                sum_d   = loop_sum;
                carry_d = loop_carry;
                a_d     = a_q << SHIFT;
                b_d     = {{SHIFT{b_q[B_W-1]}}, b_q[B_W-1:SHIFT]};
                cnt_d   = cnt_q + 6'(CELL_NUM);
                if (cnt_d == 6'(BOOTH_DIGITS)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                lo_d    = cpa_lo;
                hi_d    = cpa_hi;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset; outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign busy       = busy_q;
    assign res_ready  = ready_q;
    assign product_lo = lo_q;
    assign product_hi = hi_q;

endmodule
